// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, frame constants and bit-timing helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    function automatic int calc_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pad inputs, reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic m;

    always_ff @(posedge clk or negedge rst)
        if (!rst) {q, m} <= {2{RST_VAL}};
        else      {q, m} <= {m, d};

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 mid-bit sampling receiver with a one-byte holding register acknowledged by go.
// Define UART_RX_OVERRUN_EN to add the sticky overrun output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       go,
    output logic [7:0] data,
    output logic       data_ready
`ifdef UART_RX_OVERRUN_EN
    ,
    output logic       overrun
`endif
);

    localparam int TICKS = calc_ticks(CLK_FREQ, BAUD_RATE);
    localparam int TW    = $clog2(TICKS + 1);

    if (TICKS < 2) begin : g_bad_ticks
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    state_t                 state, state_n;
    logic [TW-1:0]          cnt, cnt_n;
    logic [2:0]             idx, idx_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   rx_s, rx_q, expire, commit;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            rx_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            rx_q  <= rx_s;
        end

    // Expiry is the last tick of a count so a reload of TICKS spans exactly one bit.
    always_comb begin
        state_n = state;
        cnt_n   = expire ? cnt : cnt - TW'(1);
        idx_n   = idx;
        shift_n = shift;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (rx_q && !rx_s) begin
                    state_n = START;
                    cnt_n   = TW'(TICKS / 2);
                end
            end
            START:
                if (expire) begin
                    state_n = rx_s ? IDLE : DATA;
                    cnt_n   = rx_s ? cnt : TW'(TICKS);
                    idx_n   = rx_s ? idx : 3'd0;
                end
            DATA:
                if (expire) begin
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    cnt_n   = TW'(TICKS);
                    idx_n   = idx + 3'd1;
                    state_n = idx == 3'(DATA_BITS - 1) ? STOP : DATA;
                end
            STOP:
                if (expire) state_n = rx_s == STOP_LEVEL ? IDLE : BREAK;
            BREAK: begin
                cnt_n   = cnt;
                state_n = rx_s ? IDLE : BREAK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        expire = cnt <= TW'(1);
        commit = state == STOP && expire && rx_s == STOP_LEVEL;
    end

    // A commit outranks a same-cycle go so the fresh byte is never lost.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            data       <= '0;
            data_ready <= 1'b0;
        end else if (commit) begin
            data       <= shift;
            data_ready <= 1'b1;
        end else if (go) begin
            data       <= '0;
            data_ready <= 1'b0;
        end

`ifdef UART_RX_OVERRUN_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst)                            overrun <= 1'b0;
        else if (commit && data_ready && !go) overrun <= 1'b1;
        else if (go)                          overrun <= 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at TICKS=2 with a byte scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk, rst, rx, go;
    logic [7:0] data;
    logic       data_ready;
`ifdef UART_RX_OVERRUN_EN
    logic       overrun;
`endif

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] sb[$];
    logic [7:0] pd = '0;
    logic       pr = 1'b0;

    uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(25_000_000)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .go(go),
        .data(data),
        .data_ready(data_ready)
`ifdef UART_RX_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        cyc(1);
        go = 1'b0;
    endtask

    // Each bit is held two clocks; check_at selects a bit after which the register must still be empty.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int check_at);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (stop) sb.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            cyc(2);
            if (i == check_at) begin
                chk("mid_data", 32'(data), 32'h0);
                chk("mid_ready", 32'(data_ready), 32'h0);
            end
        end
    endtask

    // Every new byte appearing in the holding register must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst && data_ready && (!pr || data !== pd)) begin
            logic [7:0] e;
            e = sb.size() > 0 ? sb.pop_front() : 8'hxx;
            chk("sb_byte", 32'(data), 32'(e));
        end
        pr <= data_ready;
        pd <= data;
    end

    initial begin
        rst = 1'b0;
        rx  = 1'b0;
        go  = 1'b0;
        cyc(2);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_ready", 32'(data_ready), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef UART_RX_OVERRUN_EN
        chk("rst_overrun", 32'(overrun), 32'h0);
`endif
        rx  = 1'b1;
        rst = 1'b1;
        cyc(4);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));
        chk("post_rst_ready", 32'(data_ready), 32'h0);

        send_frame(8'h55, 1'b1, 4);
        cyc(1);
        chk("lat_ready_early", 32'(data_ready), 32'h0);
        cyc(1);
        chk("f55_data", 32'(data), 32'h55);
        chk("f55_ready", 32'(data_ready), 32'h1);

        pulse_go();
        chk("go_data", 32'(data), 32'h0);
        chk("go_ready", 32'(data_ready), 32'h0);
        pulse_go();
        chk("go2_data", 32'(data), 32'h0);
        chk("go2_ready", 32'(data_ready), 32'h0);

        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        cyc(2);
        chk("b2b_data", 32'(data), 32'hA3);
        chk("b2b_ready", 32'(data_ready), 32'h1);
`ifdef UART_RX_OVERRUN_EN
        chk("b2b_overrun", 32'(overrun), 32'h1);
`endif
        pulse_go();
        chk("b2b_go_data", 32'(data), 32'h0);
        chk("b2b_go_ready", 32'(data_ready), 32'h0);
`ifdef UART_RX_OVERRUN_EN
        chk("b2b_go_overrun", 32'(overrun), 32'h0);
`endif

        send_frame(8'h3C, 1'b1, -1);
        cyc(1);
        pulse_go();
        chk("gocommit_data", 32'(data), 32'h3C);
        chk("gocommit_ready", 32'(data_ready), 32'h1);
        cyc(1);
        chk("gocommit_hold", 32'(data_ready), 32'h1);
`ifdef UART_RX_OVERRUN_EN
        chk("gocommit_overrun", 32'(overrun), 32'h0);
`endif

        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(4);
        chk("glitch_state", 32'(dut.state), 32'(IDLE));
        chk("glitch_data", 32'(data), 32'h3C);

        send_frame(8'h81, 1'b0, -1);
        cyc(10);
        chk("brk_state", 32'(dut.state), 32'(BREAK));
        chk("brk_data", 32'(data), 32'h3C);
        chk("brk_ready", 32'(data_ready), 32'h1);
        rx = 1'b1;
        cyc(4);
        chk("brk_exit", 32'(dut.state), 32'(IDLE));

        send_frame(8'h42, 1'b1, -1);
        cyc(2);
        chk("f42_data", 32'(data), 32'h42);
        chk("f42_ready", 32'(data_ready), 32'h1);
        cyc(2);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
